// File: rtl/svc_rv_dcache.sv
// ============================================================================
// Module   : svc_rv_dcache
// Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//            one-word lines between the dmem bridge and the memory fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module svc_rv_dcache #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cache_rd_valid,
    output logic        cache_rd_ready,
    input  logic [31:0] cache_rd_addr,
    output logic [31:0] cache_rd_data,
    output logic        cache_rd_data_valid,

    input  logic        cache_wr_valid,
    output logic        cache_wr_ready,
    input  logic [31:0] cache_wr_addr,
    input  logic [31:0] cache_wr_data,
    input  logic [3:0]  cache_wr_strb,

    output logic        mem_rd_valid,
    input  logic        mem_rd_ready,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_data_valid,

    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_strb
);

    localparam int C_LINES = 1 << INDEX_WIDTH;
    localparam int C_TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_MISS_REQ  = 3'd2,
        S_MISS_WAIT = 3'd3,
        S_FILL      = 3'd4,
        S_WR_MEM    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [29:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_rd_data;
    logic [C_LINES-1:0] r_valid;
    logic [C_TAG_W-1:0] r_tag  [C_LINES];
    logic [31:0]        r_data [C_LINES];

    logic [INDEX_WIDTH-1:0] w_lk_idx;
    logic [C_TAG_W-1:0]     w_lk_tag;
    logic                   w_lk_hit;
    logic [INDEX_WIDTH-1:0] w_wr_idx;
    logic [C_TAG_W-1:0]     w_wr_tag;
    logic                   w_wr_hit;
    logic                   w_rd_hs;
    logic                   w_wr_hs;
    logic                   w_fill;
    logic                   w_unused_addr_bits;

    // Lookup side always indexes with the registered request address
    assign w_lk_idx = r_addr[INDEX_WIDTH-1:0];
    assign w_lk_tag = r_addr[29:INDEX_WIDTH];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    // Write hit is resolved from the live request so the merge lands on the accept edge
    assign w_wr_idx = cache_wr_addr[INDEX_WIDTH+1:2];
    assign w_wr_tag = cache_wr_addr[31:INDEX_WIDTH+2];
    assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

    assign w_unused_addr_bits = ^{cache_rd_addr[1:0], cache_wr_addr[1:0]};

    // Readies are forced low while reset is held
    assign cache_rd_ready = rst_n && (r_state == S_IDLE);
    assign cache_wr_ready = rst_n && (r_state == S_IDLE) && !cache_rd_valid;
    assign w_rd_hs        = cache_rd_valid && cache_rd_ready;
    assign w_wr_hs        = cache_wr_valid && cache_wr_ready;
    assign w_fill         = (r_state == S_MISS_WAIT) && mem_rd_data_valid;

    assign cache_rd_data = ((r_state == S_LOOKUP) && w_lk_hit) ? r_data[w_lk_idx] : r_rd_data;
    assign mem_rd_addr   = {r_addr, 2'b00};
    assign mem_wr_addr   = {r_addr, 2'b00};
    assign mem_wr_data   = r_wdata;
    assign mem_wr_strb   = r_wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        cache_rd_data_valid = 1'b0;
        mem_rd_valid        = 1'b0;
        mem_wr_valid        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_hs) begin
                    w_state_nxt = S_LOOKUP;
                end else if (w_wr_hs) begin
                    w_state_nxt = S_WR_MEM;
                end
            end
            S_LOOKUP: begin
                if (w_lk_hit) begin
                    cache_rd_data_valid = 1'b1;
                    w_state_nxt         = S_IDLE;
                end else begin
                    w_state_nxt = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) begin
                    w_state_nxt = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (mem_rd_data_valid) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                cache_rd_data_valid = 1'b1;
                w_state_nxt         = S_IDLE;
            end
            S_WR_MEM: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rd_data <= '0;
            r_valid   <= '0;
        end else begin
            if (w_rd_hs) begin
                r_addr <= cache_rd_addr[31:2];
            end else if (w_wr_hs) begin
                r_addr  <= cache_wr_addr[31:2];
                r_wdata <= cache_wr_data;
                r_wstrb <= cache_wr_strb;
            end
            if ((r_state == S_LOOKUP) && w_lk_hit) begin
                r_rd_data <= r_data[w_lk_idx];
            end
            if (w_fill) begin
                r_rd_data          <= mem_rd_data;
                r_valid[w_lk_idx]  <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; validity lives only in r_valid
    always_ff @(posedge clk) begin
        if (w_wr_hs && w_wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (cache_wr_strb[b]) begin
                    r_data[w_wr_idx][8*b +: 8] <= cache_wr_data[8*b +: 8];
                end
            end
        end
        if (w_fill) begin
            r_data[w_lk_idx] <= mem_rd_data;
            r_tag[w_lk_idx]  <= w_lk_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_svc_rv_dcache.sv
// ============================================================================
// Module   : tb_svc_rv_dcache
// Brief    : Self-checking bench for svc_rv_dcache with a fabric memory model
//            and a transaction-level reference of cache contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_svc_rv_dcache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cache_rd_valid, cache_rd_ready, cache_rd_data_valid;
    logic [31:0] cache_rd_addr, cache_rd_data;
    logic        cache_wr_valid, cache_wr_ready;
    logic [31:0] cache_wr_addr, cache_wr_data;
    logic [3:0]  cache_wr_strb;
    logic        mem_rd_valid, mem_rd_ready, mem_rd_data_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        mem_wr_valid, mem_wr_ready;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_strb;

    always #5 clk = ~clk;

    svc_rv_dcache #(.INDEX_WIDTH(8)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cache_rd_valid      (cache_rd_valid),
        .cache_rd_ready      (cache_rd_ready),
        .cache_rd_addr       (cache_rd_addr),
        .cache_rd_data       (cache_rd_data),
        .cache_rd_data_valid (cache_rd_data_valid),
        .cache_wr_valid      (cache_wr_valid),
        .cache_wr_ready      (cache_wr_ready),
        .cache_wr_addr       (cache_wr_addr),
        .cache_wr_data       (cache_wr_data),
        .cache_wr_strb       (cache_wr_strb),
        .mem_rd_valid        (mem_rd_valid),
        .mem_rd_ready        (mem_rd_ready),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .mem_rd_data_valid   (mem_rd_data_valid),
        .mem_wr_valid        (mem_wr_valid),
        .mem_wr_ready        (mem_wr_ready),
        .mem_wr_addr         (mem_wr_addr),
        .mem_wr_data         (mem_wr_data),
        .mem_wr_strb         (mem_wr_strb)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Fabric memory (written by DUT) and reference memory (written from requests)
    logic [31:0] fab_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    int unsigned line_owner [int unsigned];

    int          rd_lat = 1, rd_stall = 0, wr_stall = 0, rd_resp = 0;
    logic [31:0] rd_pend_addr = '0;
    int          n_mem_rd = 0, dual_cnt = 0;

    logic        s_rd_rdy, s_wr_rdy, s_pulse, s_mrv, s_mwv, s_mdv, s_mrhs, s_mwhs;
    logic [31:0] s_rd_data, s_mra, s_mwa, s_mwd;
    logic [3:0]  s_mws;

    bit          res_ok, res_hit, res_acc_wr_rdy;
    int          res_lat, res_first_mrv, res_dv, res_nrd;
    logic [31:0] res_data, res_mra;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lat;
        int          stall;
        bit          exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    function automatic logic [31:0] dflt(input int unsigned w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] fab_rd(input int unsigned w);
        return fab_mem.exists(w) ? fab_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic bit m_hit(input logic [31:0] addr);
        int unsigned w;
        w = int'(addr[31:2]);
        return line_owner.exists(w % 256) && (line_owner[w % 256] == w);
    endfunction

    // One clock: drive fabric inputs, sample mid-cycle, advance, update fabric
    task automatic step();
        mem_rd_ready      = (rd_stall == 0);
        mem_wr_ready      = (wr_stall == 0);
        mem_rd_data_valid = (rd_resp == 1);
        mem_rd_data       = fab_rd(int'(rd_pend_addr[31:2]));
        #2;
        s_rd_rdy = cache_rd_ready;  s_wr_rdy = cache_wr_ready;
        s_pulse  = cache_rd_data_valid; s_rd_data = cache_rd_data;
        s_mrv = mem_rd_valid; s_mra = mem_rd_addr; s_mdv = mem_rd_data_valid;
        s_mwv = mem_wr_valid; s_mwa = mem_wr_addr; s_mwd = mem_wr_data; s_mws = mem_wr_strb;
        s_mrhs = s_mrv && mem_rd_ready;
        s_mwhs = s_mwv && mem_wr_ready;
        if (s_mrv && s_mwv) dual_cnt++;
        @(posedge clk);
        #1;
        if (rd_resp > 0) rd_resp--;
        if (s_mrv && rd_stall > 0) rd_stall--;
        if (s_mwv && wr_stall > 0) wr_stall--;
        if (s_mrhs) begin
            rd_resp = rd_lat;
            rd_pend_addr = s_mra;
            n_mem_rd++;
        end
        if (s_mwhs) fab_mem[int'(s_mwa[31:2])] = merge(fab_rd(int'(s_mwa[31:2])), s_mwd, s_mws);
    endtask

    task automatic do_read(input logic [31:0] addr);
        int  cyc, n0;
        bit  done;
        res_ok = 0;
        cache_rd_addr  = addr;
        cache_rd_valid = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 50) begin
            step(); cyc++; done = s_rd_rdy;
        end
        res_acc_wr_rdy = s_wr_rdy;
        if (!done) begin
            tmo("rd_accept"); cache_rd_valid = 1'b0; return;
        end
        n0 = n_mem_rd; res_lat = 0; res_first_mrv = 0; res_dv = 0; done = 0;
        while (!done && res_lat < 60) begin
            step(); res_lat++;
            if (s_mrv && res_first_mrv == 0) begin
                res_first_mrv = res_lat; res_mra = s_mra;
            end
            if (s_mdv && res_dv == 0) res_dv = res_lat;
            if (s_pulse) begin
                done = 1; res_data = s_rd_data;
            end
        end
        cache_rd_valid = 1'b0;
        if (!done) begin
            tmo("rd_pulse"); return;
        end
        res_nrd = n_mem_rd - n0;
        res_hit = (res_first_mrv == 0);
        res_ok  = 1;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input bit exp_hit,
                            input logic [31:0] exp_data);
        do_read(addr);
        if (res_ok) begin
            chk({name, "_hit"}, 32'(res_hit), 32'(exp_hit));
            chk({name, "_data"}, res_data, exp_data);
            if (exp_hit) begin
                chk({name, "_hit_lat"}, 32'(res_lat), 32'd1);
            end else begin
                chk({name, "_mem_addr"}, res_mra, {addr[31:2], 2'b00});
                chk({name, "_mrv_cycle"}, 32'(res_first_mrv), 32'd2);
                chk({name, "_fill_lat"}, 32'(res_lat), 32'(res_dv + 1));
                chk({name, "_mem_reads"}, 32'(res_nrd), 32'd1);
            end
        end
        line_owner[int'(addr[31:2]) % 256] = int'(addr[31:2]);
    endtask

    task automatic rd_model(input string name, input logic [31:0] addr);
        rd_check(name, addr, m_hit(addr), ref_rd(int'(addr[31:2])));
    endtask

    task automatic wr_check(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int stall);
        int          cyc, first, nvalid, bad, rdy_bad;
        bit          done;
        logic [31:0] p_addr, p_data;
        logic [3:0]  p_strb;
        wr_stall = stall;
        cache_wr_addr = addr; cache_wr_data = data; cache_wr_strb = strb; cache_wr_valid = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 50) begin
            step(); cyc++; done = s_wr_rdy;
        end
        cache_wr_valid = 1'b0;
        if (!done) begin
            tmo({name, "_accept"}); return;
        end
        cyc = 0; first = 0; nvalid = 0; bad = 0; rdy_bad = 0; done = 0;
        p_addr = '0; p_data = '0; p_strb = '0;
        while (!done && cyc < 60) begin
            step(); cyc++;
            if (s_mwv) begin
                nvalid++;
                if (first == 0) begin
                    first = cyc; p_addr = s_mwa; p_data = s_mwd; p_strb = s_mws;
                end else if ({s_mwa, s_mwd, s_mws} !== {p_addr, p_data, p_strb}) begin
                    bad++;
                end
            end
            if (s_rd_rdy || s_wr_rdy) rdy_bad++;
            done = s_mwhs;
        end
        if (!done) begin
            tmo({name, "_mem_wr"}); return;
        end
        chk({name, "_wr_addr"}, p_addr, {addr[31:2], 2'b00});
        chk({name, "_wr_data"}, p_data, data);
        chk({name, "_wr_strb"}, 32'(p_strb), 32'(strb));
        chk({name, "_first_valid"}, 32'(first), 32'd1);
        chk({name, "_valid_cycles"}, 32'(nvalid), 32'(stall + 1));
        chk({name, "_stable"}, 32'(bad), 32'd0);
        chk({name, "_ready_low"}, 32'(rdy_bad), 32'd0);
        ref_mem[int'(addr[31:2])] = merge(ref_rd(int'(addr[31:2])), data, strb);
    endtask

    initial begin
        int          pulses, cyc;
        bit          saw_dv, hs;
        logic [31:0] a;

        cache_rd_valid = 0; cache_rd_addr = '0;
        cache_wr_valid = 0; cache_wr_addr = '0; cache_wr_data = '0; cache_wr_strb = '0;
        mem_rd_ready = 0; mem_rd_data = '0; mem_rd_data_valid = 0; mem_wr_ready = 0;

        fab_mem[32'h100 >> 2] = 32'hDEADBEEF; ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        fab_mem[32'h500 >> 2] = 32'h12345678; ref_mem[32'h500 >> 2] = 32'h12345678;
        fab_mem[32'h204 >> 2] = 32'h00000000; ref_mem[32'h204 >> 2] = 32'h00000000;

        vecs[0]  = '{0, 32'h100, 32'h0,        4'h0, 2, 0, 0, 32'hDEADBEEF};
        vecs[1]  = '{0, 32'h100, 32'h0,        4'h0, 1, 0, 1, 32'hDEADBEEF};
        vecs[2]  = '{1, 32'h100, 32'h000000AA, 4'h1, 1, 0, 0, 32'h0};
        vecs[3]  = '{0, 32'h100, 32'h0,        4'h0, 1, 0, 1, 32'hDEADBEAA};
        vecs[4]  = '{0, 32'h500, 32'h0,        4'h0, 1, 1, 0, 32'h12345678};
        vecs[5]  = '{0, 32'h100, 32'h0,        4'h0, 3, 0, 0, 32'hDEADBEAA};
        vecs[6]  = '{1, 32'h200, 32'h11223344, 4'hF, 1, 3, 0, 32'h0};
        vecs[7]  = '{0, 32'h202, 32'h0,        4'h0, 1, 0, 0, 32'h11223344};
        vecs[8]  = '{1, 32'h200, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 32'h0};
        vecs[9]  = '{0, 32'h200, 32'h0,        4'h0, 1, 0, 1, 32'h11223344};
        vecs[10] = '{1, 32'h204, 32'hAABBCCDD, 4'h6, 1, 1, 0, 32'h0};
        vecs[11] = '{0, 32'h204, 32'h0,        4'h0, 1, 0, 0, 32'h00BBCC00};
        vecs[12] = '{1, 32'h200, 32'h55667788, 4'hC, 1, 0, 0, 32'h0};
        vecs[13] = '{0, 32'h200, 32'h0,        4'h0, 2, 2, 1, 32'h55663344};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("rst_ctrl", 32'({cache_rd_ready, cache_wr_ready, cache_rd_data_valid,
                             mem_rd_valid, mem_wr_valid}), 32'd0);
        chk("rst_rd_data", cache_rd_data, 32'd0);
        chk("rst_mem_bus", mem_rd_addr | mem_wr_addr | mem_wr_data | 32'(mem_wr_strb), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'({cache_rd_ready, cache_wr_ready}), 32'd3);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            rd_lat = vecs[i].lat;
            rd_stall = vecs[i].stall;
            if (vecs[i].is_wr)
                wr_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].stall);
            else
                rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data);
        end

        // Read and write requested together: read wins, write follows
        rd_lat = 1; rd_stall = 0;
        cache_wr_addr = 32'h300; cache_wr_data = 32'hCAFEF00D; cache_wr_strb = 4'hF;
        cache_wr_valid = 1'b1;
        rd_model("simul_rd", 32'h100);
        chk("simul_wr_ready", 32'(res_acc_wr_rdy), 32'd0);
        wr_check("simul_wr", 32'h300, 32'hCAFEF00D, 4'hF, 0);
        rd_model("simul_rd_back", 32'h300);

        // Reset while a posted write is stalled
        wr_stall = 5;
        cache_wr_addr = 32'h600; cache_wr_data = 32'h0BADF00D; cache_wr_strb = 4'hF;
        cache_wr_valid = 1'b1;
        cyc = 0; hs = 0;
        while (!hs && cyc < 20) begin
            step(); cyc++; hs = s_wr_rdy;
        end
        cache_wr_valid = 1'b0;
        step();
        chk("rstw_pre_valid", 32'(s_mwv), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_async_drop", 32'({mem_wr_valid, mem_rd_valid, cache_rd_ready, cache_wr_ready,
                                    cache_rd_data_valid}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        wr_stall = 0;
        line_owner.delete();

        // Reset while waiting on a fill; late response must be ignored
        rd_model("rst_prefill", 32'h100);
        rd_lat = 6; rd_stall = 0;
        cache_rd_addr = 32'h104; cache_rd_valid = 1'b1;
        cyc = 0; hs = 0;
        while (!hs && cyc < 20) begin
            step(); cyc++; hs = s_mrhs;
        end
        if (!hs) tmo("rstm_mem_rd");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_async_drop", 32'({mem_rd_valid, mem_wr_valid, cache_rd_ready, cache_wr_ready,
                                    cache_rd_data_valid}), 32'd0);
        cache_rd_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        line_owner.delete();
        pulses = 0; saw_dv = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_pulse) pulses++;
            if (s_mdv) saw_dv = 1;
        end
        chk("rstm_late_dv_seen", 32'(saw_dv), 32'd1);
        chk("rstm_no_pulse", 32'(pulses), 32'd0);
        rd_lat = 1;
        rd_check("rstm_reread", 32'h100, 1'b0, ref_rd(32'h100 >> 2));

        // Randomized traffic over a small address pool to force hits and conflicts
        for (int i = 0; i < 80; i++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                rd_lat = int'($urandom_range(1, 3));
                rd_stall = int'($urandom_range(0, 2));
                rd_model($sformatf("rnd%0d_rd", i), a);
            end else begin
                wr_check($sformatf("rnd%0d_wr", i), a, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)));
            end
        end

        chk("no_dual_mem_valid", 32'(dual_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
